// File: rtl/io_output_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_output_fifo_pkg
// Purpose  : Shared constants and FSM state encodings for io_output_fifo.
// Revision : 1.0 - initial release
// ============================================================================
package io_output_fifo_pkg;

    localparam int c_WORD_SIZE_DEFAULT  = 16;
    localparam int c_IO_FIFO_DEPTH_LOG2 = 3;

    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/io_output_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : io_output_fifo_if
// Purpose  : CPU-side and device-side req/ack handshakes plus FIFO status.
// Revision : 1.0 - initial release
// ============================================================================
interface io_output_fifo_if
    import io_output_fifo_pkg::*;
#(
    parameter int WORD_SIZE  = c_WORD_SIZE_DEFAULT,
    parameter int DEPTH_LOG2 = c_IO_FIFO_DEPTH_LOG2
);
    logic                  in_req;
    logic                  in_ack;
    logic [WORD_SIZE-1:0]  in_data;
    logic                  out_req;
    logic                  out_ack;
    logic [WORD_SIZE-1:0]  out_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;

    // slave: the FIFO itself; master: the CPU/device environment around it
    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, count, full, empty
    );

    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/io_output_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram
// Purpose  : Synchronous-write, asynchronous-read register array.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram
    import io_output_fifo_pkg::*;
#(
    parameter int WORD_SIZE  = c_WORD_SIZE_DEFAULT,
    parameter int DEPTH_LOG2 = c_IO_FIFO_DEPTH_LOG2
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic [DEPTH_LOG2-1:0] wr_addr,
    input  wire logic [WORD_SIZE-1:0]  wr_data,
    input  wire logic [DEPTH_LOG2-1:0] rd_addr,
    output      logic [WORD_SIZE-1:0]  rd_data
);
    logic [WORD_SIZE-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/io_output_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_output_fifo
// Purpose  : Buffers CPU output-port stores and replays them to io_output.
// Revision : 1.0 - initial release
// ============================================================================
module io_output_fifo
    import io_output_fifo_pkg::*;
#(
    parameter int WORD_SIZE  = c_WORD_SIZE_DEFAULT,
    parameter int DEPTH_LOG2 = c_IO_FIFO_DEPTH_LOG2
) (
    input  wire logic       clk,
    input  wire logic       areset,
    io_output_fifo_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    in_state_t             r_in_state,  w_in_state_nxt;
    out_state_t            r_out_state, w_out_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WORD_SIZE-1:0]  r_out_data;
    logic [WORD_SIZE-1:0]  w_rd_data;
    logic                  r_hold_off;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    fifo_ram #(
        .WORD_SIZE  (WORD_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.in_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // A request still held from before reset must drop before it can be
    // accepted, otherwise the same store would be written twice.
    always_comb begin
        w_in_state_nxt = r_in_state;
        w_push         = 1'b0;
        case (r_in_state)
            IN_IDLE: begin
                if (bus.in_req && !w_full && !r_hold_off) begin
                    w_push         = 1'b1;
                    w_in_state_nxt = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!bus.in_req) begin
                    w_in_state_nxt = IN_IDLE;
                end
            end
            default: w_in_state_nxt = IN_IDLE;
        endcase
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        case (r_out_state)
            OUT_IDLE: begin
                if (!w_empty) begin
                    w_load          = 1'b1;
                    w_out_state_nxt = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (bus.out_ack) begin
                    w_pop           = 1'b1;
                    w_out_state_nxt = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!bus.out_ack) begin
                    w_out_state_nxt = OUT_IDLE;
                end
            end
            default: w_out_state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_hold_off  <= 1'b1;
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_data <= w_rd_data;
            end
            if (!bus.in_req) begin
                r_hold_off <= 1'b0;
            end
        end
    end

    assign bus.in_ack   = (r_in_state == IN_ACK);
    assign bus.out_req  = (r_out_state == OUT_REQ);
    assign bus.out_data = r_out_data;
    assign bus.count    = r_count;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_io_output_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_output_fifo
// Purpose  : Self-checking bench for io_output_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_output_fifo;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    io_output_fifo_if #(.WORD_SIZE(16), .DEPTH_LOG2(3)) bus ();

    io_output_fifo #(.WORD_SIZE(16), .DEPTH_LOG2(3)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    int          rx_cnt  = 0;

    bit dev_en    = 1'b0;
    bit dev_rand  = 1'b0;
    bit man_ack   = 1'b0;
    int dev_delay = 0;
    int dev_cnt   = 0;

    typedef struct {
        logic [15:0] data;
        int          delay;
        logic [15:0] exp_out;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Device model: acks each presented word after dev_delay cycles and
    // compares it with the oldest word the CPU handed over.
    initial begin
        logic [15:0] e;
        bus.out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!dev_en) begin
                bus.out_ack = man_ack;
                dev_cnt     = 0;
            end else if (bus.out_ack) begin
                if (!bus.out_req) bus.out_ack = 1'b0;
            end else if (bus.out_req) begin
                if (dev_cnt >= dev_delay) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_extra_word: actual=%0h required=none", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_order", 32'(bus.out_data), 32'(e));
                    end
                    rx_cnt++;
                    bus.out_ack = 1'b1;
                    dev_cnt     = 0;
                    if (dev_rand) dev_delay = int'($urandom_range(0, 5));
                end else begin
                    dev_cnt++;
                end
            end
        end
    end

    task automatic cpu_write(input logic [15:0] d, input int hold);
        int t;
        bus.in_req  = 1'b1;
        bus.in_data = d;
        t = 0;
        while (!bus.in_ack && t < 300) begin
            tick();
            t++;
        end
        check("in_ack_seen", 32'(bus.in_ack), 32'd1);
        if (bus.in_ack) exp_q.push_back(d);
        repeat (hold) tick();
        bus.in_req = 1'b0;
        t = 0;
        while (bus.in_ack && t < 50) begin
            tick();
            t++;
        end
        check("in_ack_release", 32'(bus.in_ack), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (!(bus.count == 0 && !bus.out_req && exp_q.size() == 0) && t < 1000) begin
            tick();
            t++;
        end
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({name, "_count"}, 32'(bus.count), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rx0;
        logic [15:0] e;

        vecs[0] = '{data: 16'h0041, delay: 0, exp_out: 16'h0041};
        vecs[1] = '{data: 16'hFFFF, delay: 2, exp_out: 16'hFFFF};
        vecs[2] = '{data: 16'h0000, delay: 1, exp_out: 16'h0000};
        vecs[3] = '{data: 16'hA5A5, delay: 5, exp_out: 16'hA5A5};

        areset      = 1'b1;
        bus.in_req  = 1'b0;
        bus.in_data = 16'h0;
        tick();
        tick();
        check("rst_in_ack",   32'(bus.in_ack),   32'd0);
        check("rst_out_req",  32'(bus.out_req),  32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_full",     32'(bus.full),     32'd0);
        areset = 1'b0;
        tick();

        // Single-word transfers with exact handshake timing
        dev_en = 1'b1;
        foreach (vecs[i]) begin
            dev_delay   = vecs[i].delay;
            rx0         = rx_cnt;
            bus.in_req  = 1'b1;
            bus.in_data = vecs[i].data;
            tick();
            check("sw_in_ack",     32'(bus.in_ack),  32'd1);
            check("sw_count1",     32'(bus.count),   32'd1);
            check("sw_out_req_lo", 32'(bus.out_req), 32'd0);
            exp_q.push_back(vecs[i].data);
            bus.in_req = 1'b0;
            tick();
            check("sw_in_ack_lo",  32'(bus.in_ack),   32'd0);
            check("sw_out_req_hi", 32'(bus.out_req),  32'd1);
            check("sw_out_data",   32'(bus.out_data), 32'(vecs[i].exp_out));
            wait_drain("sw_drain");
            check("sw_rx", 32'(rx_cnt - rx0), 32'd1);
            check("sw_empty", 32'(bus.empty), 32'd1);
        end

        // Fill to capacity with the device stalled
        dev_en = 1'b0;
        dev_delay = 0;
        rx0 = rx_cnt;
        for (int i = 0; i < 8; i++) cpu_write(16'h0030 + 16'(i), 0);
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd8);
        bus.in_req  = 1'b1;
        bus.in_data = 16'h0038;
        repeat (4) tick();
        check("fill_no_ack", 32'(bus.in_ack), 32'd0);
        check("fill_count_hold", 32'(bus.count), 32'd8);
        dev_en = 1'b1;
        begin
            int t;
            t = 0;
            while (!bus.in_ack && t < 100) begin
                tick();
                t++;
            end
        end
        check("fill_9th_ack", 32'(bus.in_ack), 32'd1);
        check("fill_9th_count", 32'(bus.count), 32'd8);
        exp_q.push_back(16'h0038);
        bus.in_req = 1'b0;
        wait_drain("fill_drain");
        check("fill_rx", 32'(rx_cnt - rx0), 32'd9);

        // Push and pop on the same edge at count 3
        dev_en = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(16'h0100 + 16'(i), 0);
        tick();
        check("sim_count_pre", 32'(bus.count), 32'd3);
        check("sim_out_req", 32'(bus.out_req), 32'd1);
        e = exp_q.pop_front();
        check("sim_front", 32'(bus.out_data), 32'(e));
        bus.in_req  = 1'b1;
        bus.in_data = 16'h0123;
        man_ack     = 1'b1;
        tick();
        check("sim_in_ack", 32'(bus.in_ack), 32'd1);
        check("sim_count",  32'(bus.count),  32'd3);
        check("sim_out_req_lo", 32'(bus.out_req), 32'd0);
        exp_q.push_back(16'h0123);
        man_ack    = 1'b0;
        bus.in_req = 1'b0;
        tick();
        dev_en = 1'b1;
        wait_drain("sim_drain");

        // Stream through the pointer wrap with random device latency
        dev_rand  = 1'b1;
        dev_delay = 3;
        rx0 = rx_cnt;
        for (int i = 0; i < 20; i++) begin
            cpu_write(16'(i), 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain("wrap_drain");
        check("wrap_rx", 32'(rx_cnt - rx0), 32'd20);
        dev_rand  = 1'b0;
        dev_delay = 0;

        // Request held long after acknowledge
        dev_en = 1'b0;
        cpu_write(16'h0055, 10);
        tick();
        check("held_count", 32'(bus.count), 32'd1);
        dev_en = 1'b1;
        rx0 = rx_cnt;
        wait_drain("held_drain");
        check("held_rx", 32'(rx_cnt - rx0), 32'd1);

        // Reset in the middle of both handshakes
        dev_en = 1'b0;
        for (int i = 0; i < 4; i++) cpu_write(16'h0200 + 16'(i), 0);
        check("mr_count_pre", 32'(bus.count), 32'd4);
        check("mr_out_req_pre", 32'(bus.out_req), 32'd1);
        bus.in_req  = 1'b1;
        bus.in_data = 16'h0077;
        areset      = 1'b1;
        tick();
        areset = 1'b0;
        exp_q.delete();
        check("mr_in_ack", 32'(bus.in_ack),  32'd0);
        check("mr_out_req", 32'(bus.out_req), 32'd0);
        check("mr_count",  32'(bus.count),   32'd0);
        check("mr_empty",  32'(bus.empty),   32'd1);
        repeat (3) tick();
        check("mr_held_no_ack", 32'(bus.in_ack), 32'd0);
        check("mr_held_count",  32'(bus.count),  32'd0);
        bus.in_req = 1'b0;
        tick();
        bus.in_req = 1'b1;
        tick();
        check("mr_new_ack",   32'(bus.in_ack), 32'd1);
        check("mr_new_count", 32'(bus.count),  32'd1);
        exp_q.push_back(16'h0077);
        bus.in_req = 1'b0;
        dev_en = 1'b1;
        rx0 = rx_cnt;
        wait_drain("mr_drain");
        check("mr_rx", 32'(rx_cnt - rx0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/io_output_fifo.md
Name: io_output_fifo

Overview:
- Buffered output stage between the CPU's memory-mapped output port and the io_output device.
- Accepts words from the CPU over a 4-phase req/ack handshake and stores them in a FIFO.
- Replays each word to the output device over a second 4-phase req/ack handshake.
- Decouples CPU store latency from device latency; CPU stalls only when the FIFO is full.

Parameters:
- WORD_SIZE, `WORD_SIZE, width of each data word.
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).

Ports:
- clk  input  1  clock
- areset  input  1  reset; synchronous, active-high
- in_req  input  1  CPU-side request; held high until in_ack seen
- in_ack  output  1  CPU-side acknowledge
- in_data  input  WORD_SIZE  CPU write data; stable while in_req high
- out_req  output  1  device-side request
- out_ack  input  1  device-side acknowledge
- out_data  output  WORD_SIZE  word presented to device; stable while out_req high
- count  output  DEPTH_LOG2+1  current FIFO occupancy
- full  output  1  count == 2**DEPTH_LOG2
- empty  output  1  count == 0

Behaviour:
- Reset: at a clk edge with areset high:
  - rd_ptr, wr_ptr and count become 0.
  - in_ack = 0, out_req = 0, out_data = 0.
  - Both FSMs return to IDLE; FIFO contents are discarded.
  - areset has priority over all other events.
- Reset mid-handshake: any in-flight transfer is abandoned with no write and no pop. After reset the upstream FSM waits for in_req low before accepting again, which prevents a double write of a held request.
- Input FSM (states IN_IDLE, IN_ACK):
  - IN_IDLE, in_req=1 and full=0: write in_data to mem[wr_ptr], wr_ptr++, count++, enter IN_ACK. in_ack goes high the cycle after the edge.
  - IN_IDLE, in_req=1 and full=1: stay in IN_IDLE, no write, in_ack stays 0. The write occurs at the first edge where full=0.
  - IN_ACK, in_req=0: enter IN_IDLE, in_ack goes low. While in_req stays high, stay in IN_ACK; exactly one write per handshake.
- Output FSM (states OUT_IDLE, OUT_REQ, OUT_WAIT):
  - OUT_IDLE, empty=0: out_data <= mem[rd_ptr], out_req <= 1, enter OUT_REQ.
  - OUT_REQ, out_ack=1: out_req <= 0, rd_ptr++, count--, enter OUT_WAIT. out_data holds its value.
  - OUT_WAIT, out_ack=0: enter OUT_IDLE.
- Latency:
  - A word written at edge k into an empty FIFO raises out_req at edge k+1 at the earliest.
  - Each device transfer takes at least 4 edges against io_output: WAITREQ -> DOWORK -> WAITACK -> release.
- Simultaneous push and pop on the same edge: count unchanged; both pointers advance.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- count is a DEPTH_LOG2+1 bit register; it must never exceed depth or underflow.
- Ordering is strict FIFO; no word is ever dropped except by reset.

Decomposition:
- Add to defines.vh:
  - `IO_FIFO_IN_IDLE, `IO_FIFO_IN_ACK (1-bit encoding).
  - `IO_FIFO_OUT_IDLE, `IO_FIFO_OUT_REQ, `IO_FIFO_OUT_WAIT (2-bit encoding).
  - `IO_FIFO_DEPTH_LOG2 default.
- One natural sub-module, fifo_ram: a synchronous-write, asynchronous-read register array (WORD_SIZE x 2**DEPTH_LOG2) with wr_en, wr_addr, wr_data, rd_addr, rd_data.
- FSMs, pointers and count live in io_output_fifo.

Test Plan:
- Single word: in_data=0x0041 handshake, device acks promptly -> in_ack high 1 cycle after req sampled; out_req rises; out_data=0x0041 until out_req drops; count returns 0; io_output writes 'A'.
- Fill: device holds out_ack=0 and stays in OUT_REQ; push 8 words 0x30..0x37 -> full=1, count=8; 9th in_req gets no in_ack. Release device -> 9th accepted after the first pop; output order 0x30..0x38.
- Simultaneous push/pop: align CPU write edge with device ack edge at count=3 -> count stays 3; no lost or duplicated word.
- Wrap: stream 20 words 0x00..0x13 through depth 8 with random ack delays 0..5 cycles -> output sequence identical to input; pointers wrap without error.
- Held request: keep in_req high for 10 cycles after in_ack -> exactly one write; count increments by 1.
- Reset mid-operation: assert areset while in OUT_REQ with count=4 and in_req high -> next cycle in_ack=0, out_req=0, count=0, empty=1; no write until in_req drops and rises again.
